// File: rtl/probe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : probe_sequencer
// Purpose  : Per-trigger shot sequencer for four ultrasonic channels. Each
//            enabled channel gets an A/B burst, a dead time and a sampled
//            window. Optional macro PROBE_SEQ_TESTPAT_EN replaces ADC data
//            with the in-window sample index.
// Revision : 1.0 - initial release
// ============================================================================
module probe_sequencer #(
    parameter int PULSE_W  = 8,
    parameter int DEAD_CYC = 16,
    parameter int SMP_CNT  = 256,
    parameter int SMP_DIV  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trig,
    input  logic [3:0]  ch_mask,
    input  logic [3:0]  half_per,
    input  logic [11:0] d_0x,
    input  logic [11:0] d_1x,
    input  logic [11:0] d_2x,
    input  logic [11:0] d_3x,
    output logic [3:0]  phase_a,
    output logic [3:0]  phase_b,
    output logic [3:0]  rx_en,
    output logic [3:0]  pdwn,
    output logic [15:0] smp_data,
    output logic        smp_last,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic        busy,
    output logic        done,
    output logic        ovr,
    output logic        trig_miss
);

    localparam logic [15:0] c_PW_LAST   = 16'(PULSE_W - 1);
    localparam logic [15:0] c_DEAD_LAST = 16'(DEAD_CYC - 1);
    localparam logic [15:0] c_DIV_LAST  = 16'(SMP_DIV - 1);
    localparam logic [11:0] c_SMP_LAST  = 12'(SMP_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_DEAD   = 3'd3,
        S_ACQ    = 3'd4
    } state_t;

    state_t      r_state, w_state;
    logic [1:0]  r_ch, w_ch;
    logic [2:0]  r_ptr, w_ptr;
    logic [3:0]  r_mask, w_mask;
    logic [3:0]  r_hp, w_hp;
    logic [15:0] r_cnt, w_cnt;
    logic [3:0]  r_half, w_half;
    logic [11:0] r_smp, w_smp;
    logic        w_start, w_done, w_stb, w_miss;
    logic        w_sel_found;
    logic [1:0]  w_sel_ch;
    logic [11:0] w_adc, w_smp_field;
    logic [3:0]  w_oh;
    logic        w_active;
    logic        r_cap_vld, r_cap_last;
    logic [15:0] r_cap_data;

    // Descending scan so the lowest enabled channel at or above ptr wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_ch    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_mask[i] && (3'(i) >= r_ptr)) begin
                w_sel_found = 1'b1;
                w_sel_ch    = 2'(i);
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_ch    = r_ch;
        w_ptr   = r_ptr;
        w_mask  = r_mask;
        w_hp    = r_hp;
        w_cnt   = r_cnt;
        w_half  = r_half;
        w_smp   = r_smp;
        w_start = 1'b0;
        w_done  = 1'b0;
        w_stb   = 1'b0;
        w_miss  = trig && (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (trig && (ch_mask != 4'h0)) begin
                    w_start = 1'b1;
                    w_mask  = ch_mask;
                    w_hp    = half_per;
                    w_ptr   = 3'd0;
                    w_state = S_SELECT;
                end
            end
            S_SELECT: begin
                w_cnt  = '0;
                w_half = '0;
                w_smp  = '0;
                if (w_sel_found) begin
                    w_ch    = w_sel_ch;
                    w_state = (r_hp == 4'd0) ? S_DEAD : S_PULSE;
                end else begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                end
            end
            S_PULSE: begin
                if (r_cnt == c_PW_LAST) begin
                    w_cnt = '0;
                    if (r_half == (r_hp - 4'd1)) begin
                        w_state = S_DEAD;
                    end else begin
                        w_half = r_half + 4'd1;
                    end
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            S_DEAD: begin
                if (r_cnt == c_DEAD_LAST) begin
                    w_cnt   = '0;
                    w_state = S_ACQ;
                    w_stb   = 1'b1;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            S_ACQ: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_cnt = '0;
                    if (r_smp == c_SMP_LAST) begin
                        w_state = S_SELECT;
                        w_ptr   = {1'b0, r_ch} + 3'd1;
                    end else begin
                        w_smp = r_smp + 12'd1;
                        w_stb = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_comb begin
        case (w_ch)
            2'd0:    w_adc = d_0x;
            2'd1:    w_adc = d_1x;
            2'd2:    w_adc = d_2x;
            default: w_adc = d_3x;
        endcase
    end

`ifdef PROBE_SEQ_TESTPAT_EN
    logic w_unused_adc;
    assign w_unused_adc = ^w_adc;
    assign w_smp_field  = w_smp;
`else
    assign w_smp_field  = w_adc;
`endif

    assign w_oh     = 4'b0001 << w_ch;
    assign w_active = (w_state == S_PULSE) || (w_state == S_DEAD) || (w_state == S_ACQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ch    <= 2'd0;
            r_ptr   <= 3'd0;
            r_mask  <= 4'h0;
            r_hp    <= 4'h0;
            r_cnt   <= '0;
            r_half  <= '0;
            r_smp   <= '0;
        end else begin
            r_state <= w_state;
            r_ch    <= w_ch;
            r_ptr   <= w_ptr;
            r_mask  <= w_mask;
            r_hp    <= w_hp;
            r_cnt   <= w_cnt;
            r_half  <= w_half;
            r_smp   <= w_smp;
        end
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_a    <= 4'h0;
            phase_b    <= 4'h0;
            rx_en      <= 4'h0;
            pdwn       <= 4'hF;
            busy       <= 1'b0;
            done       <= 1'b0;
            r_cap_vld  <= 1'b0;
            r_cap_last <= 1'b0;
            r_cap_data <= 16'h0;
            smp_data   <= 16'h0;
            smp_last   <= 1'b0;
            smp_valid  <= 1'b0;
            ovr        <= 1'b0;
            trig_miss  <= 1'b0;
        end else begin
            phase_a   <= ((w_state == S_PULSE) && !w_half[0]) ? w_oh : 4'h0;
            phase_b   <= ((w_state == S_PULSE) &&  w_half[0]) ? w_oh : 4'h0;
            rx_en     <= w_active ? w_oh : 4'h0;
            pdwn      <= w_active ? ~w_oh : 4'hF;
            busy      <= (w_state != S_IDLE);
            done      <= w_done;
            r_cap_vld <= w_stb;
            if (w_stb) begin
                r_cap_data <= {w_ch, 2'b00, w_smp_field};
                r_cap_last <= (w_smp == c_SMP_LAST);
            end
            if (r_cap_vld) begin
                smp_data  <= r_cap_data;
                smp_last  <= r_cap_last;
                smp_valid <= 1'b1;
            end else if (smp_ready) begin
                smp_valid <= 1'b0;
            end
            ovr       <= (ovr & ~w_start) | (r_cap_vld & smp_valid & ~smp_ready);
            trig_miss <= (trig_miss & ~w_start) | w_miss;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_probe_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_probe_sequencer
// Purpose  : Directed self-checking bench for probe_sequencer with a
//            cycle-accurate expected-waveform monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_probe_sequencer;

    localparam int PW = 8;
    localparam int DC = 16;
    localparam int SC = 256;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trig;
    logic [3:0]  ch_mask;
    logic [3:0]  half_per;
    logic [11:0] d_0x, d_1x, d_2x, d_3x;
    logic [3:0]  phase_a, phase_b, rx_en, pdwn;
    logic [15:0] smp_data;
    logic        smp_last, smp_valid, smp_ready;
    logic        busy, done, ovr, trig_miss;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] adc(input int k, input int c);
        return {2'(k), 10'(c * 3)};
    endfunction

    assign d_0x = adc(0, cyc);
    assign d_1x = adc(1, cyc);
    assign d_2x = adc(2, cyc);
    assign d_3x = adc(3, cyc);

    probe_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .trig      (trig),
        .ch_mask   (ch_mask),
        .half_per  (half_per),
        .d_0x      (d_0x),
        .d_1x      (d_1x),
        .d_2x      (d_2x),
        .d_3x      (d_3x),
        .phase_a   (phase_a),
        .phase_b   (phase_b),
        .rx_en     (rx_en),
        .pdwn      (pdwn),
        .smp_data  (smp_data),
        .smp_last  (smp_last),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .busy      (busy),
        .done      (done),
        .ovr       (ovr),
        .trig_miss (trig_miss)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    bit         mon_on = 1'b0;
    int         mon_base, mon_win, mon_nwin, mon_hp, mon_n;
    int         e_phase, e_chan, e_busy, e_done, e_data, e_time, e_last;
    int         ovr_t, miss_t;
    logic [1:0] mon_ch [4];

    // Expected waveform from the window timeline: SELECT, PULSE, DEAD, ACQ.
    always @(negedge clk) begin
        int t, w, u, k, arr;
        logic [3:0]  oh, xa, xb, xr;
        logic [11:0] xs;
        if (mon_on) begin
            t  = cyc - mon_base;
            xa = 4'h0;
            xb = 4'h0;
            xr = 4'h0;
            if (t < mon_nwin * mon_win) begin
                w = t / mon_win;
                u = t % mon_win;
                if (u != 0) begin
                    oh = 4'b0001 << mon_ch[w];
                    xr = oh;
                    if (u <= mon_hp * PW) begin
                        if (((u - 1) / PW) % 2 == 0) xa = oh;
                        else xb = oh;
                    end
                end
            end
            if (phase_a !== xa || phase_b !== xb) e_phase++;
            if (rx_en !== xr || pdwn !== ~xr) e_chan++;
            if (busy !== (t <= mon_nwin * mon_win)) e_busy++;
            if (done !== (t == mon_nwin * mon_win + 1)) e_done++;
            if (ovr && ovr_t < 0) ovr_t = t;
            if (trig_miss && miss_t < 0) miss_t = t;
            if (smp_valid && smp_ready) begin
                w = mon_n / SC;
                k = mon_n % SC;
                if (w < mon_nwin) begin
                    arr = mon_base + w * mon_win + 1 + mon_hp * PW + DC + 1 + SD * k;
                    if (cyc != arr) e_time++;
`ifdef PROBE_SEQ_TESTPAT_EN
                    xs = 12'(k);
`else
                    xs = adc(mon_ch[w], arr - 2);
`endif
                    if (smp_data !== {mon_ch[w], 2'b00, xs}) e_data++;
                    if (smp_last !== (k == SC - 1)) e_last++;
                end else begin
                    e_data++;
                end
                mon_n++;
            end
        end
    end

    task automatic run_seq(input string tag, input logic [3:0] mask, input logic [3:0] hp,
                           input int x_ovr_t, input int x_miss_t);
        int nw;
        nw = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                mon_ch[nw] = 2'(i);
                nw++;
            end
        end
        mon_nwin = nw;
        mon_hp   = int'(hp);
        mon_win  = 1 + mon_hp * PW + DC + SC * SD;
        mon_n    = 0;
        e_phase  = 0; e_chan = 0; e_busy = 0; e_done = 0;
        e_data   = 0; e_time = 0; e_last = 0;
        ovr_t    = -1;
        miss_t   = -1;
        @(posedge clk); #1;
        ch_mask  = mask;
        half_per = hp;
        trig     = 1'b1;
        @(posedge clk); #1;
        mon_base = cyc;
        trig     = 1'b0;
        mon_on   = 1'b1;
        repeat (nw * mon_win + 4) @(posedge clk);
        #1;
        mon_on = 1'b0;
        check({tag, "_phase_errs"}, e_phase, 0);
        check({tag, "_chan_errs"},  e_chan,  0);
        check({tag, "_busy_errs"},  e_busy,  0);
        check({tag, "_done_errs"},  e_done,  0);
        check({tag, "_time_errs"},  e_time,  0);
        check({tag, "_data_errs"},  e_data,  0);
        check({tag, "_last_errs"},  e_last,  0);
        check({tag, "_nsmp"},       mon_n,   smp_ready ? nw * SC : 0);
        check({tag, "_ovr_t"},      ovr_t,   x_ovr_t);
        check({tag, "_miss_t"},     miss_t,  x_miss_t);
    endtask

    initial begin
        logic [11:0] xs;
        int          arr;
        reset_n   = 1'b0;
        trig      = 1'b0;
        ch_mask   = 4'h0;
        half_per  = 4'h0;
        smp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_phase_a",   phase_a,   4'h0);
        check("rst_phase_b",   phase_b,   4'h0);
        check("rst_rx_en",     rx_en,     4'h0);
        check("rst_pdwn",      pdwn,      4'hF);
        check("rst_smp_data",  smp_data,  16'h0);
        check("rst_smp_valid", smp_valid, 1'b0);
        check("rst_smp_last",  smp_last,  1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_ovr",       ovr,       1'b0);
        check("rst_trig_miss", trig_miss, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("idle_busy", busy, 1'b0);

        // Two channels, full bursts, consumer always ready.
        run_seq("t1", 4'b0101, 4'd4, -1, -1);

        // Stalled consumer: second sample load overruns at t=30.
        smp_ready = 1'b0;
        run_seq("t3", 4'b0001, 4'd1, 30, -1);
        arr = mon_base + 1 + PW + DC + 1 + SD * (SC - 1);
`ifdef PROBE_SEQ_TESTPAT_EN
        xs = 12'(SC - 1);
`else
        xs = adc(0, arr - 2);
`endif
        check("t3_valid_held", smp_valid, 1'b1);
        check("t3_ovr",        ovr,       1'b1);
        check("t3_last",       smp_last,  1'b1);
        check("t3_data",       smp_data,  {4'b0000, xs});
        @(posedge clk); #1;
        smp_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_drain", smp_valid, 1'b0);

        // No burst; ovr from previous run must be cleared by this trigger.
        run_seq("t4", 4'b0010, 4'd0, -1, -1);

        // Trigger during ACQ is flagged and otherwise ignored.
        fork
            run_seq("t5", 4'b0100, 4'd2, -1, 200);
            begin
                repeat (201) @(posedge clk);
                #1;
                trig     = 1'b1;
                ch_mask  = 4'hF;
                half_per = 4'hF;
                @(posedge clk); #1;
                trig = 1'b0;
            end
        join
        @(posedge clk); #1;
        ch_mask = 4'h0;
        trig    = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        check("t5_m0_busy_a", busy, 1'b0);
        repeat (2) @(posedge clk); #1;
        check("t5_m0_busy_b", busy,      1'b0);
        check("t5_m0_miss",   trig_miss, 1'b1);

        // Asynchronous reset in the middle of a burst.
        @(posedge clk); #1;
        ch_mask  = 4'b0001;
        half_per = 4'd4;
        trig     = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("t6_pre_phase_a", phase_a, 4'b0001);
        reset_n = 1'b0;
        #1;
        check("t6_phase_a", phase_a, 4'h0);
        check("t6_phase_b", phase_b, 4'h0);
        check("t6_pdwn",    pdwn,    4'hF);
        check("t6_rx_en",   rx_en,   4'h0);
        check("t6_busy",    busy,    1'b0);
        #2;
        reset_n = 1'b1;
        run_seq("t6", 4'b1000, 4'd1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/probe_sequencer.md
# probe_sequencer

Shot sequencer for the four ultrasonic channels of the stick board. On each sounding trigger (wheel tick or external sync, already synchronized to `clk`) it walks the enabled channels in ascending order. For each channel it drives a phase A/B excitation burst, holds a dead time, then captures a fixed-length window of samples from that channel's 12-bit ADC into a one-deep output stream for the packetizer in `stick_main`.

## Interface
Parameters:
- `PULSE_W`, 8: clocks per excitation half-period (≥1)
- `DEAD_CYC`, 16: clocks between burst end and first sample (≥1)
- `SMP_CNT`, 256: samples per channel window (≥1, ≤4096)
- `SMP_DIV`, 4: clocks per sample strobe (≥1)

Ports:
- `clk` in 1: system clock
- `reset_n` in 1: asynchronous reset, active low
- `trig` in 1: single-cycle sounding start
- `ch_mask` in 4: channel enables, latched at trigger
- `half_per` in 4: burst length in half-periods, latched at trigger
- `d_0x`, `d_1x`, `d_2x`, `d_3x` in 12 each: ADC data per channel
- `phase_a`, `phase_b` out 4: excitation drive, one bit per channel
- `rx_en` out 4: receiver enable, one-hot on the active channel
- `pdwn` out 4: power-down, low only on the active channel
- `smp_data` out 16: {ch[1:0], 2'b00, sample[11:0]}
- `smp_last` out 1: marks the last sample of a window
- `smp_valid` out 1, `smp_ready` in 1: output handshake
- `busy` out 1: sequence in progress
- `done` out 1: one-cycle pulse at sequence end
- `ovr` out 1: sticky overrun flag
- `trig_miss` out 1: sticky flag, trigger seen while busy

## Operation
- State machine: IDLE → SELECT → PULSE → DEAD → ACQ → SELECT … → IDLE.
- **IDLE:**
  - `trig` with `ch_mask`≠0 latches `ch_mask` and `half_per`, clears `ovr` and `trig_miss`, sets ptr=0 and goes to SELECT.
  - `trig` with `ch_mask`=0 is ignored.
- **SELECT (1 clk):**
  - Chooses the lowest enabled channel ≥ptr as `ch`, then goes to PULSE.
  - If no channel is left, goes to IDLE, pulses `done` and deasserts `busy`.
- **PULSE:**
  - Lasts `half_per`×`PULSE_W` clks.
  - Even half-periods (0, 2, …) drive `phase_a[ch]`=1; odd ones drive `phase_b[ch]`=1.
  - `phase_a` and `phase_b` are never high together.
  - `half_per`=0 skips straight to DEAD.
- **DEAD:** `DEAD_CYC` clks; phases are 0 and `rx_en[ch]`=1.
- **ACQ:**
  - A strobe fires every `SMP_DIV` clks, the first on ACQ entry.
  - Each strobe captures `d_<ch>x` into the output register, sets `smp_valid`, and sets `smp_last` on sample `SMP_CNT`-1.
  - After the last strobe plus `SMP_DIV` clks, sets ptr=`ch`+1 and goes to SELECT.
- **Handshake:**
  - `smp_valid` holds until `smp_valid`&`smp_ready`.
  - A strobe while `smp_valid` is high and `smp_ready` is low overwrites the register and sets `ovr`.
  - A strobe coinciding with acceptance is not an overrun.
- **Channel outputs:** `rx_en`/`pdwn` follow `ch` from PULSE through ACQ. In IDLE and SELECT, `rx_en`=0 and `pdwn`=4'hF.
- **Busy triggers:** `trig` while busy is ignored and sets `trig_miss`.

## Timing
- **Reset values:** `phase_a`=`phase_b`=`rx_en`=0, `pdwn`=4'hF, `smp_data`=0, `smp_valid`=`smp_last`=0, `busy`=`done`=`ovr`=`trig_miss`=0. State is IDLE.
- **Outputs:** all are registered.
- **Trigger latency:** `trig` sampled at edge N gives `busy`=1 at N+1 and the first phase drive at N+2.
- **Sample latency:** the sample strobe at edge M gives `smp_data`/`smp_valid` valid after edge M+1; ADC data is sampled at edge M.
- **Reset mid-operation:** `reset_n` low at any time immediately forces the reset values. No partial window is flushed.
- **Window duration:** per channel, 1 + `half_per`·`PULSE_W` + `DEAD_CYC` + `SMP_CNT`·`SMP_DIV` clks.

## Configuration
- `PROBE_SEQ_TESTPAT_EN`:
  - Defined: the sample field carries the 12-bit in-window sample index (0…`SMP_CNT`-1) instead of ADC data; everything else is unchanged.
  - Undefined: the sample field carries real ADC data.

## Test plan
- Reset, `ch_mask`=4'b0101, `half_per`=4, `smp_ready`=1, defaults → ch0 then ch2 windows.
  - Each window has 4×8 clks of alternating `phase_a`/`phase_b` on its bit only.
  - Each window yields 256 samples with `smp_last` on the 256th.
  - `done` pulses after the ch2 window; `ovr`=0.
- `PROBE_SEQ_TESTPAT_EN` with `ch_mask`=4'b1000 → `smp_data` runs 16'hC000…16'hC0FF.
- `smp_ready`=0 throughout one window → exactly one `smp_valid` held; `ovr`=1 after the second strobe; `ovr` clears on the next accepted `trig`.
- `half_per`=0, `ch_mask`=4'b0010 → no phase activity; the first strobe comes 1+16 clks after SELECT.
- `trig` pulsed mid-ACQ → `trig_miss`=1 and the sequence continues unchanged; `ch_mask`=0 trig in IDLE → `busy` stays 0.
- `reset_n` dropped during PULSE → `phase_a`/`phase_b` go to 0 and `pdwn` goes to 4'hF immediately; the next `trig` runs normally.
